// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: memory-side responder that turns one 256-bit cache line
// request into a 4-beat 64-bit burst, then returns a single-cycle pmem_resp.
// Optional feature macro: CACHELINE_ADAPTOR_WRAP_EN (critical-word-first order).
module cacheline_adaptor #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64,
    parameter int unsigned s_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata,
    output logic [s_line-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [s_burst-1:0] burst_o,
    input  logic [s_burst-1:0] burst_i,
    input  logic               resp_i
);
    localparam int unsigned cw = $clog2(s_beats);
    localparam int unsigned lo = $clog2(s_line / 8);
    localparam int unsigned bo = $clog2(s_burst / 8);

    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, HOLD} state_t;

    state_t            state, next_state;
    logic [cw-1:0]     cnt, start, start_in, idx, idx_next;
    logic [s_line-1:0] line, line_d;
    logic [31:0]       addr_in;
    logic              last_beat, accept;
    logic              unused_addr_bits;

`ifdef CACHELINE_ADAPTOR_WRAP_EN
    assign start_in = pmem_address[lo-1:bo];
    assign addr_in  = {pmem_address[31:bo], {bo{1'b0}}};
`else
    assign start_in = '0;
    assign addr_in  = {pmem_address[31:lo], {lo{1'b0}}};
`endif
    // Low offset bits only matter in wrap mode
    assign unused_addr_bits = ^pmem_address[lo-1:0];

    assign idx       = cnt + start;
    assign idx_next  = idx + cw'(1);
    assign last_beat = resp_i && (cnt == cw'(s_beats - 1));
    assign accept    = (state == IDLE) && (next_state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: write wins over read; HOLD waits for the request to drop
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pmem_write)     next_state = WRITE;
                else if (pmem_read) next_state = READ;
            end
            READ, WRITE: if (last_beat) next_state = RESP;
            RESP:        next_state = HOLD;
            HOLD:        if (!pmem_read && !pmem_write) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Line buffer next value: write data captured at accept, read beats slotted by idx
    always_comb begin
        line_d = line;
        if (accept && pmem_write)
            line_d = pmem_wdata;
        else if (state == READ && resp_i)
            line_d[s_burst*idx +: s_burst] = burst_i;
    end

    // Datapath and registered outputs, all decoded from next_state so they
    // line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            line       <= '0;
            cnt        <= '0;
            start      <= '0;
            address_o  <= '0;
            burst_o    <= '0;
            pmem_rdata <= '0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            pmem_resp  <= 1'b0;
        end else begin
            line      <= line_d;
            read_o    <= (next_state == READ);
            write_o   <= (next_state == WRITE);
            pmem_resp <= (next_state == RESP);
            if (accept) begin
                cnt       <= '0;
                start     <= start_in;
                address_o <= addr_in;
                if (pmem_write)
                    burst_o <= pmem_wdata[s_burst*start_in +: s_burst];
            end else if ((state == READ || state == WRITE) && resp_i) begin
                cnt <= cnt + cw'(1);
                if (state == WRITE)
                    burst_o <= line[s_burst*idx_next +: s_burst];
            end
            if (next_state == RESP)
                pmem_rdata <= line_d;
        end
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines/beats are queued when
// a request is driven and popped as the adaptor produces them.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pmem_address = '0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i = '0;
    logic         resp_i = 1'b0;

    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    logic [255:0] exp_q[$];

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk(clk), .rst(rst),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int unsigned start_of(input logic [31:0] a);
`ifdef CACHELINE_ADAPTOR_WRAP_EN
        return int'(a[4:3]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_ADAPTOR_WRAP_EN
        return a & ~32'h7;
`else
        return a & ~32'h1F;
`endif
    endfunction

    function automatic logic [255:0] build_line(input logic [31:0] a,
            input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0]  bb[4];
        logic [255:0] l;
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        l = '0;
        for (int k = 0; k < 4; k++) l[64*((start_of(a) + k) % 4) +: 64] = bb[k];
        return l;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called on a negedge with the adaptor idle; returns on a negedge with it idle again.
    task automatic run_read(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic [15:0] pat, input int unsigned hold);
        logic [63:0]  bb[4];
        logic [255:0] line;
        int unsigned  k = 0;
        int unsigned  cyc = 0;
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        pmem_address = addr;
        pmem_read    = 1'b1;
        exp_q.push_back(build_line(addr, b0, b1, b2, b3));
        @(negedge clk);
        check("rd_read_o", read_o, 1'b1);
        check("rd_addr", address_o, exp_addr(addr));
        pmem_address = ~addr;
        while (k < 4 && cyc < 32) begin
            if (cyc >= 16 || pat[cyc]) begin
                resp_i = 1'b1; burst_i = bb[k]; k++;
            end else begin
                resp_i = 1'b0; burst_i = rnd64();
            end
            cyc++;
            @(negedge clk);
            if (k < 4) begin
                check("rd_busy", {read_o, pmem_resp}, 2'b10);
                check("rd_addr_stable", address_o, exp_addr(addr));
            end
        end
        resp_i = 1'b0;
        check("rd_resp", {read_o, pmem_resp}, 2'b01);
        line = exp_q.pop_front();
        check("rd_rdata", pmem_rdata, line);
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rd_hold_no_retrigger", {read_o, write_o, pmem_resp}, 3'b000);
        end
        pmem_read = 1'b0;
        @(negedge clk);
        check("rd_resp_pulse", pmem_resp, 1'b0);
        check("rd_rdata_kept", pmem_rdata, line);
        @(negedge clk);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [255:0] wd,
                             input logic [15:0] pat, input logic both);
        int unsigned k = 0;
        int unsigned cyc = 0;
        for (int j = 0; j < 4; j++)
            exp_q.push_back({192'h0, wd[64*((start_of(addr) + j) % 4) +: 64]});
        exp_q.push_back(wd);
        pmem_address = addr;
        pmem_wdata   = wd;
        pmem_write   = 1'b1;
        pmem_read    = both;
        @(negedge clk);
        check("wr_write_o", {write_o, read_o}, 2'b10);
        check("wr_addr", address_o, exp_addr(addr));
        pmem_address = ~addr;
        pmem_wdata   = ~wd;
        while (k < 4 && cyc < 32) begin
            check("wr_burst", burst_o, exp_q[0][63:0]);
            if (cyc >= 16 || pat[cyc]) begin
                resp_i = 1'b1; k++;
                void'(exp_q.pop_front());
            end else begin
                resp_i = 1'b0;
            end
            burst_i = rnd64();
            cyc++;
            @(negedge clk);
            if (k < 4) check("wr_busy", {write_o, read_o, pmem_resp}, 3'b100);
        end
        resp_i = 1'b0;
        check("wr_resp", {write_o, pmem_resp}, 2'b01);
        check("wr_rdata", pmem_rdata, exp_q.pop_front());
        pmem_write = 1'b0;
        pmem_read  = 1'b0;
        @(negedge clk);
        check("wr_resp_pulse", pmem_resp, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {read_o, write_o, pmem_resp}, 3'b000);
        check("rst_addr", address_o, 32'h0);
        check("rst_burst", burst_o, 64'h0);
        check("rst_rdata", pmem_rdata, 256'h0);
        rst = 1'b0;
        @(negedge clk);

        run_read(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 16'hFFFF, 0);
        run_write(32'h0000_2040, {64'hD3D3_0000_3333_0003, 64'hD2D2_0000_2222_0002,
                                  64'hD1D1_0000_1111_0001, 64'hD0D0_0000_0000_0000},
                  16'h0059, 1'b0);
        run_read(32'h0000_3008, rnd64(), rnd64(), rnd64(), rnd64(), 16'hFFFF, 3);
        run_read(32'h0000_3100, rnd64(), rnd64(), rnd64(), rnd64(), 16'h00AD, 0);
        run_write(32'h0000_4018, {rnd64(), rnd64(), rnd64(), rnd64()}, 16'hFFFF, 1'b1);

        // Abort a read after two beats
        pmem_address = 32'h0000_5000;
        pmem_read    = 1'b1;
        @(negedge clk);
        check("abort_read_o", read_o, 1'b1);
        resp_i = 1'b1;
        burst_i = rnd64();
        @(negedge clk);
        burst_i = rnd64();
        @(negedge clk);
        resp_i = 1'b0;
        rst = 1'b1;
        pmem_read = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {read_o, write_o, pmem_resp}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", {read_o, write_o, pmem_resp}, 3'b000);
        run_read(32'h0000_6000, rnd64(), rnd64(), rnd64(), rnd64(), 16'h0F0F, 0);

        run_read(32'h0000_0050, 64'hB0B0_B0B0_B0B0_B0B0, 64'hB1B1_B1B1_B1B1_B1B1,
                 64'hB2B2_B2B2_B2B2_B2B2, 64'hB3B3_B3B3_B3B3_B3B3, 16'h00B5, 0);
        run_write(32'h0000_0070, {rnd64(), rnd64(), rnd64(), rnd64()}, 16'h0093, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
